// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N:1 registered multiplexer.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Round-robin pointer advance: the channel after the granted one, wrapping to 0.
  function automatic int unsigned ptrInc(input int unsigned idx, input int unsigned n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Stateless round-robin arbiter: first active request at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int N_CH  = 4,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req_i,
  input  logic [SEL_W-1:0] ptr_i,
  output logic [N_CH-1:0]  grantOh_o,
  output logic [SEL_W-1:0] grantIdx_o,
  output logic             grantValid_o
);

  logic [SEL_W-1:0] k;

  always_comb begin
    grantOh_o    = '0;
    grantIdx_o   = '0;
    grantValid_o = 1'b0;
    k            = '0;
    for (int i = 0; i < N_CH; i++) begin
      k = SEL_W'((32'(ptr_i) + 32'(i)) % 32'(N_CH));
      if (!grantValid_o && req_i[k]) begin
        grantValid_o  = 1'b1;
        grantIdx_o    = k;
        grantOh_o[k]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_nto1_reg.sv
// N-input registered mux with valid/ready handshake, fixed or round-robin selection.
// Optional feature: define MUX_PARITY_EN to add a registered even-parity output.
module mux_nto1_reg
  import mux_pkg::*;
#(
  parameter  int N_CH  = 4,
  parameter  int WIDTH = 8,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      selector,
  input  logic [N_CH*WIDTH-1:0] data_in,
  input  logic [N_CH-1:0]       valid_in,
  output logic [N_CH-1:0]       ready_out,
  output logic [WIDTH-1:0]      data_out,
  output logic                  valid_out,
  input  logic                  ready_in
`ifdef MUX_PARITY_EN
  ,
  output logic                  parity_out
`endif
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic [N_CH-1:0]  arbOh, fixedOh, gOh;
  logic [SEL_W-1:0] arbIdx, gIdx;
  logic             arbValid, fixedHit, grantValid, canLoad;
  logic [WIDTH-1:0] selData;

  rr_arbiter #(.N_CH(N_CH), .SEL_W(SEL_W)) uArb (
    .req_i       (valid_in),
    .ptr_i       (ptr_q),
    .grantOh_o   (arbOh),
    .grantIdx_o  (arbIdx),
    .grantValid_o(arbValid)
  );

  // Fixed mode: an out-of-range selector simply matches no channel.
  always_comb begin
    fixedHit = 1'b0;
    fixedOh  = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (selector == SEL_W'(k) && valid_in[k]) begin
        fixedHit   = 1'b1;
        fixedOh[k] = 1'b1;
      end
    end
  end

  always_comb begin
    gIdx       = (mode == MODE_RR) ? arbIdx   : selector;
    gOh        = (mode == MODE_RR) ? arbOh    : fixedOh;
    grantValid = (mode == MODE_RR) ? arbValid : fixedHit;
    canLoad    = !valid_q || ready_in;
    ready_out  = (canLoad && grantValid && !reset) ? gOh : '0;
    selData    = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (gIdx == SEL_W'(k)) selData = data_in[k*WIDTH +: WIDTH];
    end
  end

  // A load empties or refills the output slot; the pointer only moves on RR transfers.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (canLoad) begin
      valid_d = grantValid;
      if (grantValid) begin
        data_d = selData;
        if (mode == MODE_RR) ptr_d = SEL_W'(ptrInc(32'(gIdx), N_CH));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;

`ifdef MUX_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else if (canLoad && grantValid) begin
      parity_q <= ^selData;
    end
  end

  assign parity_out = parity_q;
`endif

endmodule

// File: tb/tb_mux_nto1_reg.sv
// Directed self-checking bench for mux_nto1_reg (N_CH=4, WIDTH=8).
module tb_mux_nto1_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        mode;
  logic [1:0]  selector;
  logic [31:0] data_in;
  logic [3:0]  valid_in;
  logic [3:0]  ready_out;
  logic [7:0]  data_out;
  logic        valid_out;
  logic        ready_in;
`ifdef MUX_PARITY_EN
  logic        parity_out;
`endif

  int checks   = 0;
  int failures = 0;

  mux_nto1_reg #(.N_CH(4), .WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .mode     (mode),
    .selector (selector),
    .data_in  (data_in),
    .valid_in (valid_in),
    .ready_out(ready_out),
    .data_out (data_out),
    .valid_out(valid_out),
    .ready_in (ready_in)
`ifdef MUX_PARITY_EN
    ,
    .parity_out(parity_out)
`endif
  );

  always #2 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic m, input logic [1:0] s, input logic [31:0] d,
                               input logic [3:0] v, input logic rdy);
    mode     = m;
    selector = s;
    data_in  = d;
    valid_in = v;
    ready_in = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] rrSeq [5] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h01};
  logic [3:0] rrOh  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 2'd0, 32'h44332211, 4'b1111, 1'b1);
    tick();
    tick();
    checkOutput("rst_valid", 32'(valid_out), 32'd0);
    checkOutput("rst_data", 32'(data_out), 32'd0);
    checkOutput("rst_ready", 32'(ready_out), 32'd0);

    // Fixed selection hit
    reset = 1'b0;
    applyStimulus(1'b0, 2'd2, 32'h00A50000, 4'b0100, 1'b1);
    #1;
    checkOutput("fix_ready", 32'(ready_out), 32'b0100);
    tick();
    checkOutput("fix_data", 32'(data_out), 32'hA5);
    checkOutput("fix_valid", 32'(valid_out), 32'd1);

    // Fixed selection miss: slot drains, data holds
    applyStimulus(1'b0, 2'd1, 32'h00A50000, 4'b0100, 1'b1);
    #1;
    checkOutput("miss_ready", 32'(ready_out), 32'd0);
    tick();
    checkOutput("miss_valid", 32'(valid_out), 32'd0);
    checkOutput("miss_hold", 32'(data_out), 32'hA5);

    // Round-robin fairness with full throughput and 3->0 wrap
    applyStimulus(1'b1, 2'd0, 32'h04030201, 4'b1111, 1'b1);
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput($sformatf("rr_ready%0d", i), 32'(ready_out), 32'(rrOh[i]));
      tick();
      checkOutput($sformatf("rr_data%0d", i), 32'(data_out), 32'(rrSeq[i]));
      checkOutput($sformatf("rr_valid%0d", i), 32'(valid_out), 32'd1);
`ifdef MUX_PARITY_EN
      checkOutput($sformatf("rr_par%0d", i), 32'(parity_out), 32'(^rrSeq[i]));
`endif
    end

    // Backpressure: load 3C, stall 3 cycles while a new word waits
    applyStimulus(1'b0, 2'd3, 32'h3C000000, 4'b1000, 1'b1);
    tick();
    checkOutput("bp_load", 32'(data_out), 32'h3C);
    applyStimulus(1'b0, 2'd3, 32'h5A000000, 4'b1000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput($sformatf("bp_ready%0d", i), 32'(ready_out), 32'd0);
      tick();
      checkOutput($sformatf("bp_data%0d", i), 32'(data_out), 32'h3C);
      checkOutput($sformatf("bp_valid%0d", i), 32'(valid_out), 32'd1);
    end
    ready_in = 1'b1;
    #1;
    checkOutput("bp_release_ready", 32'(ready_out), 32'b1000);
    tick();
    checkOutput("bp_next_data", 32'(data_out), 32'h5A);
    checkOutput("bp_next_valid", 32'(valid_out), 32'd1);
    valid_in = 4'b0000;
    tick();
    checkOutput("bp_no_dup", 32'(valid_out), 32'd0);
    checkOutput("bp_hold", 32'(data_out), 32'h5A);

    // Round-robin skip from ptr=1, then reset while holding a word
    applyStimulus(1'b1, 2'd0, 32'h33000011, 4'b1001, 1'b1);
    #1;
    checkOutput("skip_ready3", 32'(ready_out), 32'b1000);
    tick();
    checkOutput("skip_data3", 32'(data_out), 32'h33);
    checkOutput("skip_ready0", 32'(ready_out), 32'b0001);
    tick();
    checkOutput("skip_data0", 32'(data_out), 32'h11);
    checkOutput("skip_valid", 32'(valid_out), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_ready", 32'(ready_out), 32'd0);
    tick();
    checkOutput("mid_rst_valid", 32'(valid_out), 32'd0);
    checkOutput("mid_rst_data", 32'(data_out), 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("post_rst_grant", 32'(ready_out), 32'b0001);
    tick();
    checkOutput("post_rst_data", 32'(data_out), 32'h11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
